// File: rtl/rom_arb_pkg.sv
// Shared constants, FSM state type and window-base helper for the ROM port arbiter.
package rom_arb_pkg;

  localparam int N_PORTS = 8;
  localparam int WINDOW  = 25;
  localparam int DEPTH   = 200;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int IW      = $clog2(N_PORTS);
  localparam int PW      = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  // Physical base of a port's window; 9 bits so the sum with a local address cannot wrap.
  function automatic logic [PW-1:0] base_of(input logic [IW-1:0] idx);
    return PW'(int'(idx) * WINDOW);
  endfunction

endpackage

// File: rtl/rom_arb_if.sv
// Core-side request/response bus plus the ROM address/data pair seen by the arbiter.
interface rom_arb_if;
  import rom_arb_pkg::*;

  logic [N_PORTS-1:0]    req;
  logic [N_PORTS*AW-1:0] addr;
  logic [N_PORTS-1:0]    ack;
  logic [N_PORTS*DW-1:0] rdata;
  logic [N_PORTS-1:0]    err;
  logic [AW-1:0]         rom_addr;
  logic [DW-1:0]         rom_data;
  logic                  busy;

  modport master (
    output req, addr, rom_data,
    input  ack, rdata, err, rom_addr, busy
  );

  modport slave (
    input  req, addr, rom_data,
    output ack, rdata, err, rom_addr, busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting port after the last granted one.
module rr_picker
  import rom_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = i_last;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      w_cand = IW'((int'(i_last) + k) % N_PORTS);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one clocked single-port ROM between eight cores,
// each confined to its own 25-byte window.
module rom_port_arbiter
  import rom_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  rom_arb_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic               w_start;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_grant;
  logic [N_PORTS-1:0] r_grant_oh;
  logic               r_oor;
  logic [N_PORTS-1:0] w_gnt_oh;
  logic [IW-1:0]      w_idx;
  logic [AW-1:0]      w_local;
  logic [PW-1:0]      w_phys;
  logic               w_oor;

  rr_picker u_picker (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_idx)
  );

  assign w_local = bus.addr[w_idx*AW +: AW];
  assign w_phys  = base_of(w_idx) + PW'(w_local);
  assign w_oor   = (w_local >= AW'(WINDOW)) || (w_phys >= PW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_start = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.busy = (r_state != IDLE);

  // Grant capture in IDLE, result return in CAPTURE; ack/err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last       <= IW'(N_PORTS - 1);
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_oor        <= 1'b0;
      bus.ack      <= '0;
      bus.err      <= '0;
      bus.rdata    <= '0;
      bus.rom_addr <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      if (w_start) begin
        r_grant      <= w_idx;
        r_grant_oh   <= w_gnt_oh;
        r_oor        <= w_oor;
        bus.rom_addr <= w_oor ? '0 : w_phys[AW-1:0];
      end
      if (r_state == CAPTURE) begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (r_grant_oh[i]) bus.rdata[i*DW +: DW] <= r_oor ? '0 : bus.rom_data;
        end
        bus.ack <= r_grant_oh;
        bus.err <= r_oor ? r_grant_oh : '0;
        r_last  <= r_grant;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter; the ROM model returns each byte's own address.
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rom_arb_if bus();

  rom_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency ROM whose content equals its address.
  always @(posedge clk) begin
    bus.rom_data <= (bus.rom_addr < 8'(DEPTH)) ? bus.rom_addr : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic [7:0] a, input logic r);
    bus.addr[p*AW +: AW] = a;
    bus.req[p]           = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    rst_n   = 1'b0;
    bus.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic doSingle(input int p, input logic [7:0] a, input logic [7:0] expRom,
                          input logic [7:0] expData, input logic expErr, input string tag);
    logic [7:0] m;
    m = 8'h01 << p;
    applyStimulus(p, a, 1'b1);
    tick();
    checkOutput({tag, "_romaddr"}, 64'(bus.rom_addr), 64'(expRom));
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    tick();
    checkOutput({tag, "_early_ack"}, 64'(bus.ack), 64'd0);
    tick();
    checkOutput({tag, "_ack"}, 64'(bus.ack), 64'(m));
    checkOutput({tag, "_err"}, 64'(bus.err), expErr ? 64'(m) : 64'd0);
    checkOutput({tag, "_rdata"}, 64'(bus.rdata[p*DW +: DW]), 64'(expData));
    applyStimulus(p, a, 1'b0);
    tick();
    checkOutput({tag, "_ack_done"}, 64'(bus.ack), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int ackPort [8];
    int ackCyc  [8];
    int n;
    checks   = 0;
    errors   = 0;
    bus.req  = '0;
    bus.addr = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    checkOutput("rst_ack", 64'(bus.ack), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);
    checkOutput("rst_rdata", bus.rdata, 64'd0);
    checkOutput("rst_romaddr", 64'(bus.rom_addr), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);

    doSingle(0, 8'd3, 8'd3, 8'd3, 1'b0, "p0_a3");
    doSingle(2, 8'd5, 8'd55, 8'd55, 1'b0, "p2_a5");
    checkOutput("p2_others_kept", bus.rdata, 64'h0000_0000_0037_0003);

    // Three simultaneous requesters from reset: expect 0, 3, 7 three cycles apart.
    resetDut();
    checkOutput("rst2_rdata", bus.rdata, 64'd0);
    bus.addr = '0;
    bus.addr[3*AW +: AW] = 8'd1;
    bus.req = 8'h89;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.ack != 0) begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (bus.ack[i] && n < 8) begin
            ackPort[n] = i;
            ackCyc[n]  = c;
            n++;
          end
        end
        bus.req = bus.req & ~bus.ack;
      end
    end
    checkOutput("rr3_count", 64'(n), 64'd3);
    checkOutput("rr3_first", 64'(ackPort[0]), 64'd0);
    checkOutput("rr3_second", 64'(ackPort[1]), 64'd3);
    checkOutput("rr3_third", 64'(ackPort[2]), 64'd7);
    checkOutput("rr3_cyc0", 64'(ackCyc[0]), 64'd3);
    checkOutput("rr3_cyc1", 64'(ackCyc[1]), 64'd6);
    checkOutput("rr3_cyc2", 64'(ackCyc[2]), 64'd9);

    // All eight held high: one ack every third cycle, port 0 first after port 7.
    bus.req = 8'hFF;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c % 3 == 0) checkOutput($sformatf("rr8_ack_c%0d", c), 64'(bus.ack), 64'(8'h01 << (c/3 - 1)));
      else            checkOutput($sformatf("rr8_gap_c%0d", c), 64'(bus.ack), 64'd0);
    end
    bus.req = '0;
    checkOutput("rr8_rdata", bus.rdata, 64'hAF96_7D64_4C32_1900);
    tick();
    checkOutput("rr8_idle", 64'(bus.busy), 64'd0);

    doSingle(7, 8'd24, 8'd199, 8'd199, 1'b0, "p7_a24");
    doSingle(7, 8'd25, 8'd0, 8'd0, 1'b1, "p7_a25_oor");

    // Address change right after grant must not affect the transaction.
    applyStimulus(4, 8'd10, 1'b1);
    tick();
    bus.addr[4*AW +: AW] = 8'd20;
    checkOutput("p4_romaddr", 64'(bus.rom_addr), 64'd110);
    tick();
    checkOutput("p4_romaddr_hold", 64'(bus.rom_addr), 64'd110);
    tick();
    checkOutput("p4_ack", 64'(bus.ack), 64'h10);
    checkOutput("p4_rdata", 64'(bus.rdata[4*DW +: DW]), 64'd110);
    applyStimulus(4, 8'd20, 1'b0);
    tick();

    // Reset while port 1 is in ISSUE; port 5 waits and must win afterwards.
    applyStimulus(1, 8'd2, 1'b1);
    tick();
    checkOutput("p1_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    applyStimulus(5, 8'd4, 1'b1);
    #1;
    checkOutput("abort_ack", 64'(bus.ack), 64'd0);
    checkOutput("abort_rdata", bus.rdata, 64'd0);
    checkOutput("abort_romaddr", 64'(bus.rom_addr), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    applyStimulus(1, 8'd2, 1'b0);
    tick();
    tick();
    checkOutput("abort_no_ack", 64'(bus.ack), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("p5_romaddr", 64'(bus.rom_addr), 64'd129);
    tick();
    tick();
    checkOutput("p5_ack", 64'(bus.ack), 64'h20);
    checkOutput("p5_rdata", 64'(bus.rdata[5*DW +: DW]), 64'd129);
    applyStimulus(5, 8'd4, 1'b0);
    tick();
    checkOutput("p5_done", 64'(bus.ack), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Round-robin arbiter that lets eight PicoBlaze cores share one single-port, 200-byte program-data ROM. Each core sees a private 25-byte window selected by its port index. The arbiter sits directly upstream of the ROM. It collects per-core read requests, adds the window base, drives the single ROM address port, captures the ROM data, and returns it to the requesting core with a one-cycle acknowledge.

## Interface
Parameters:
- `N_PORTS`, 8: number of requesting cores.
- `WINDOW`, 25: bytes per core window; base of port i = i*WINDOW.
- `DEPTH`, 200: ROM depth in bytes.
- `AW`, 8: address width, local and ROM.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_PORTS  per-port read request, level; held high until `ack` for that port.
- `addr`  in  N_PORTS*AW  per-port local address; port i occupies bits [i*AW +: AW].
- `ack`  out  N_PORTS  per-port one-cycle completion pulse.
- `rdata`  out  N_PORTS*DW  per-port read data; valid with `ack`, held until that port's next `ack`.
- `err`  out  N_PORTS  one-cycle pulse coincident with `ack` when local addr >= WINDOW.
- `rom_addr`  out  AW  address to ROM, registered.
- `rom_data`  in  DW  ROM output; valid exactly one cycle after `rom_addr` is presented.
- `busy`  out  1  high while a transaction is in flight (state != IDLE).

## Operation
- FSM states:
  - IDLE: if any `req` bit is high, pick a grant g round-robin, starting at `last+1` mod N_PORTS. Register g, compute `phys = g*WINDOW + addr[g]` in 9 bits, load `rom_addr`, go to ISSUE.
  - ISSUE: the ROM samples `rom_addr`. Go to CAPTURE.
  - CAPTURE: write `rdata[g] <= rom_data` (or 0x00 when out of range), pulse `ack[g]` (and `err[g]` when out of range), set `last <= g`, go to IDLE.
- Out of range: local addr >= WINDOW, or phys >= DEPTH.
  - `rom_addr` is driven to 0.
  - The returned data is forced to 0x00 and `err[g]` pulses.
  - Latency is unchanged.
- `addr[g]` is sampled only in IDLE at grant. Changes after grant are ignored.
- A request dropped after grant still completes and acks. The core must ignore the ack.
- A `req` still high in the cycle its `ack` pulses is treated as a new request at the next IDLE evaluation. Cores deassert `req` on seeing `ack`.
- Non-granted ports keep their `rdata` unchanged.

## Timing
- Reset values: `ack`=0, `err`=0, `rdata`=all 0, `rom_addr`=0, `busy`=0, state=IDLE, `last`=N_PORTS-1 (port 0 has first priority).
- Latency: `req` sampled high in IDLE at edge E0 -> `rom_addr` valid after E0 -> `ack`/`rdata` valid after E2. Three cycles from the sampling edge.
- Throughput: one transaction per 3 cycles, with no idle gap between back-to-back grants.
- Simultaneous requests: serviced strictly round-robin. With all 8 requesting continuously, each port is acked once per 24 cycles.
- Reset mid-transaction:
  - Aborts immediately; no `ack` for the aborted grant.
  - `rdata` is cleared and `last` returns to N_PORTS-1.
- Starvation-free: any held `req` is acked within N_PORTS*3 cycles.

## Structure
- Shared package `rom_arb_pkg`:
  - state enum {IDLE, ISSUE, CAPTURE};
  - constants N_PORTS, WINDOW, DEPTH;
  - base-offset function `i*WINDOW`.
- Sub-module `rr_picker`: combinational. Inputs `req` and `last`; outputs one-hot grant and its index. It is the only sub-module.
- The ROM stays a separate instance outside this block, with one clocked read port.

## Test plan
- Reset, then port 0 requests addr 3 -> `rom_addr`=3 one cycle later; `ack[0]` pulses 3 cycles after sampling; `rdata[0]`=0x03.
- Port 2 requests addr 5 -> `rom_addr`=55; `rdata[2]`=55; all other `rdata` unchanged.
- Ports 0, 3 and 7 request together from reset -> acks in order 0, 3, 7, spaced 3 cycles apart. Next round with all 8 requesting starts at port 0 after port 7.
- Port 7 requests addr 24 -> phys 199, `rdata[7]`=199. Port 7 requests addr 25 -> `rom_addr`=0, `rdata[7]`=0x00, `err[7]` pulses with `ack[7]`.
- Port 4 changes `addr` from 10 to 20 the cycle after grant -> `rom_addr`=110 and the result uses the address sampled at grant.
- Assert `rst_n`=0 during ISSUE for port 1 -> no `ack[1]`, all outputs return to reset values. After release, a pending `req[5]` is granted first.
